// File: rtl/cg_ptw_pkg.sv
// cg_ptw_sv39 shared types, widths and PTE field positions.
// Build option: CG_PTW_SUPERPAGE_EN accepts aligned superpage leaves.
package cg_ptw_pkg;

  localparam int VADDR_WIDTH  = 39;
  localparam int PADDR_WIDTH  = 56;
  localparam int PPN_WIDTH    = 44;
  localparam int OFFSET_WIDTH = 12;
  localparam int ASID_WIDTH   = 16;
  localparam int PTE_WIDTH    = 64;

  localparam int LEVELS   = 3;
  localparam int VPN_BITS = 9;

  localparam int PTE_V       = 0;
  localparam int PTE_R       = 1;
  localparam int PTE_W       = 2;
  localparam int PTE_X       = 3;
  localparam int PTE_PPN_LSB = 10;
  localparam int PTE_PPN_MSB = 53;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DONE,
    FAULT,
    HOLD
  } ptw_state_e;

  typedef struct packed {
    logic [9:0]           rsvd;
    logic [PPN_WIDTH-1:0] ppn;
    logic [1:0]           rsw;
    logic                 d;
    logic                 a;
    logic                 g;
    logic                 u;
    logic                 x;
    logic                 w;
    logic                 r;
    logic                 v;
  } pte_t;

  function automatic logic [VPN_BITS-1:0] vpn_of(
    input logic [LEVELS*VPN_BITS-1:0] vpn,
    input logic [1:0]                 lvl
  );
    logic [VPN_BITS-1:0] sel;
    sel = vpn[VPN_BITS-1:0];
    unique case (1'b1)
      lvl == 2'd2: sel = vpn[3*VPN_BITS-1:2*VPN_BITS];
      lvl == 2'd1: sel = vpn[2*VPN_BITS-1:VPN_BITS];
      default:     sel = vpn[VPN_BITS-1:0];
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/cg_ptw_sv39_if.sv
// Miss/result and PTE read-port bundle of the Sv39 walker.
// master = walker side, slave = TLB and memory side.
interface cg_ptw_sv39_if;
  import cg_ptw_pkg::*;

  logic [PPN_WIDTH-1:0]   i_satp_ppn;
  logic                   i_tlb_miss;
  logic [VADDR_WIDTH-1:0] i_tlb_miss_vaddr;
  logic [ASID_WIDTH-1:0]  i_asid;
  logic                   o_ptw_valid;
  logic [PADDR_WIDTH-1:0] o_ptw_paddr;
  logic [ASID_WIDTH-1:0]  o_ptw_asid;
  logic                   o_ptw_fault;
  logic                   o_mem_req_valid;
  logic                   i_mem_req_ready;
  logic [PADDR_WIDTH-1:0] o_mem_req_addr;
  logic                   i_mem_resp_valid;
  logic [PTE_WIDTH-1:0]   i_mem_resp_data;

  modport master (
    input  i_satp_ppn, i_tlb_miss,
    input  i_tlb_miss_vaddr, i_asid,
    output o_ptw_valid, o_ptw_paddr,
    output o_ptw_asid, o_ptw_fault,
    output o_mem_req_valid, o_mem_req_addr,
    input  i_mem_req_ready,
    input  i_mem_resp_valid, i_mem_resp_data
  );

  modport slave (
    output i_satp_ppn, i_tlb_miss,
    output i_tlb_miss_vaddr, i_asid,
    input  o_ptw_valid, o_ptw_paddr,
    input  o_ptw_asid, o_ptw_fault,
    input  o_mem_req_valid, o_mem_req_addr,
    output i_mem_req_ready,
    output i_mem_resp_valid, i_mem_resp_data
  );

endinterface

// File: rtl/cg_ptw_pte_check.sv
// Combinational PTE decode for one walk level.
// leaf_ppn splices the skipped VPN bits in for superpages.
module cg_ptw_pte_check
  import cg_ptw_pkg::*;
(
  input  pte_t                    pte,
  input  logic [1:0]              level,
  input  logic [2*VPN_BITS-1:0]   vpn_lo,
  output logic                    is_invalid,
  output logic                    is_leaf,
  output logic                    is_misaligned,
  output logic [PPN_WIDTH-1:0]    leaf_ppn
);

  logic [PTE_WIDTH-1:0] raw;
  logic [PPN_WIDTH-1:0] ppn;
  logic                 unused_bits;

  assign raw = pte;
  assign ppn = raw[PTE_PPN_MSB:PTE_PPN_LSB];
  assign unused_bits = ^{raw[63:54], raw[9:4]};

  assign is_invalid = !raw[PTE_V] ||
                      (!raw[PTE_R] && raw[PTE_W]);
  assign is_leaf = raw[PTE_R] | raw[PTE_X];

  // Alignment test and PPN merge depend on the leaf's level.
  always_comb begin
    is_misaligned = 1'b0;
    leaf_ppn      = ppn;
    unique case (1'b1)
      level == 2'd2: begin
        is_misaligned = |ppn[2*VPN_BITS-1:0];
        leaf_ppn = {ppn[PPN_WIDTH-1:2*VPN_BITS],
                    vpn_lo};
      end
      level == 2'd1: begin
        is_misaligned = |ppn[VPN_BITS-1:0];
        leaf_ppn = {ppn[PPN_WIDTH-1:VPN_BITS],
                    vpn_lo[VPN_BITS-1:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cg_ptw_sv39.sv
// Sv39 page-table walker, one PTE read in flight.
// Build option: CG_PTW_SUPERPAGE_EN accepts aligned superpage leaves.
module cg_ptw_sv39
  import cg_ptw_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rstn,
  cg_ptw_sv39_if.master bus
);

  ptw_state_e             r_state;
  ptw_state_e             nxt_state;
  logic [1:0]             r_level;
  logic [PPN_WIDTH-1:0]   r_ppn;
  logic [VADDR_WIDTH-1:0] r_vaddr;
  logic [ASID_WIDTH-1:0]  r_asid;
  logic [PADDR_WIDTH-1:0] r_paddr;
  logic [VPN_BITS-1:0]    cur_vpn;
  pte_t                   resp_pte;
  logic                   is_invalid;
  logic                   is_leaf;
  logic                   is_misaligned;
  logic                   leaf_ok;
  logic [PPN_WIDTH-1:0]   leaf_ppn;

  assign resp_pte = bus.i_mem_resp_data;
  assign cur_vpn  = vpn_of(r_vaddr[VADDR_WIDTH-1:OFFSET_WIDTH],
                           r_level);

  cg_ptw_pte_check u_chk (
    .pte           (resp_pte),
    .level         (r_level),
    .vpn_lo        (r_vaddr[OFFSET_WIDTH+2*VPN_BITS-1:OFFSET_WIDTH]),
    .is_invalid    (is_invalid),
    .is_leaf       (is_leaf),
    .is_misaligned (is_misaligned),
    .leaf_ppn      (leaf_ppn)
  );

`ifdef CG_PTW_SUPERPAGE_EN
  assign leaf_ok = (r_level == 2'd0) || !is_misaligned;
`else
  logic unused_mis;
  assign unused_mis = is_misaligned;
  assign leaf_ok = (r_level == 2'd0);
`endif

  // State register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_state <= IDLE;
    else         r_state <= nxt_state;
  end

  // Walk sequencing; response only honoured in WAIT.
  always_comb begin
    nxt_state = r_state;
    unique case (r_state)
      IDLE:  if (bus.i_tlb_miss) nxt_state = REQ;
      REQ:   if (bus.i_mem_req_ready) nxt_state = WAIT;
      WAIT: begin
        if (bus.i_mem_resp_valid) begin
          if (is_invalid)          nxt_state = FAULT;
          else if (is_leaf)        nxt_state = leaf_ok ? DONE : FAULT;
          else if (r_level == 2'd0) nxt_state = FAULT;
          else                     nxt_state = REQ;
        end
      end
      DONE:    nxt_state = HOLD;
      FAULT:   nxt_state = HOLD;
      HOLD:    nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  // Strobes decoded purely from the state register.
  always_comb begin
    bus.o_mem_req_valid = 1'b0;
    bus.o_ptw_valid     = 1'b0;
    bus.o_ptw_fault     = 1'b0;
    unique case (r_state)
      REQ:     bus.o_mem_req_valid = 1'b1;
      DONE:    bus.o_ptw_valid     = 1'b1;
      FAULT:   bus.o_ptw_fault     = 1'b1;
      default: ;
    endcase
  end

  // Walk context: miss capture, pointer descent, result.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_level <= '0;
      r_ppn   <= '0;
      r_vaddr <= '0;
      r_asid  <= '0;
      r_paddr <= '0;
    end else begin
      if (r_state == IDLE && bus.i_tlb_miss) begin
        r_vaddr <= bus.i_tlb_miss_vaddr;
        r_asid  <= bus.i_asid;
        r_ppn   <= bus.i_satp_ppn;
        r_level <= 2'(LEVELS-1);
      end
      if (r_state == WAIT && nxt_state == REQ) begin
        r_ppn   <= resp_pte.ppn;
        r_level <= r_level - 2'd1;
      end
      if (r_state == WAIT && nxt_state == DONE) begin
        r_paddr <= {leaf_ppn,
                    r_vaddr[OFFSET_WIDTH-1:0]};
      end
    end
  end

  assign bus.o_mem_req_addr = {r_ppn, cur_vpn, 3'b000};
  assign bus.o_ptw_paddr    = r_paddr;
  assign bus.o_ptw_asid     = r_asid;

endmodule

// File: doc/cg_ptw_sv39.md
# cg_ptw_sv39

Sv39 hardware page-table walker that services TLB misses. It accepts a miss (`i_tlb_miss`, `i_tlb_miss_vaddr`, `i_asid`) from `cg_tlb_fullyassociative` and walks the three-level table rooted at `i_satp_ppn` through a single-outstanding memory read port. It returns either a translated physical address on `o_ptw_valid`/`o_ptw_paddr` or a page-fault pulse. It sits between the TLB fill port and the data-cache/memory read arbiter.

## Interface
- VADDR_WIDTH, 39, virtual address width; VPN fields are [38:30], [29:21], [20:12].
- PADDR_WIDTH, 56, physical address width.
- PPN_WIDTH, 44, physical page number width.
- OFFSET_WIDTH, 12, page offset width.
- ASID_WIDTH, 16, address-space ID width; latched and echoed, not used in the walk.
- PTE_WIDTH, 64, page-table entry width.
- i_clk  in  1  clock.
- i_rstn  in  1  asynchronous reset, active-low.
- i_satp_ppn  in  PPN_WIDTH  root table PPN; sampled only on miss capture.
- i_tlb_miss  in  1  level miss indication from the TLB.
- i_tlb_miss_vaddr  in  VADDR_WIDTH  missing virtual address.
- i_asid  in  ASID_WIDTH  ASID of the miss.
- o_ptw_valid  out  1  one-cycle pulse: translation ready.
- o_ptw_paddr  out  PADDR_WIDTH  {PPN, vaddr offset}; valid with o_ptw_valid.
- o_ptw_asid  out  ASID_WIDTH  latched ASID; valid with o_ptw_valid or o_ptw_fault.
- o_ptw_fault  out  1  one-cycle pulse: page fault; no fill.
- o_mem_req_valid  out  1  PTE read request.
- i_mem_req_ready  in  1  request accepted this cycle.
- o_mem_req_addr  out  PADDR_WIDTH  PTE byte address (8-byte aligned).
- i_mem_resp_valid  in  1  PTE read data valid.
- i_mem_resp_data  in  PTE_WIDTH  PTE contents.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE, FAULT, HOLD. Level counter r_level is 2 bits, values 2 down to 0.
- IDLE: on i_tlb_miss, latch vaddr, ASID and i_satp_ppn into r_ppn; set r_level=2; go to REQ.
- REQ: o_mem_req_valid=1 and o_mem_req_addr={r_ppn, vpn[r_level], 3'b000}. Address is held stable until i_mem_req_ready, then go to WAIT.
- WAIT: wait for i_mem_resp_valid. i_mem_resp_valid is ignored in every other state. Decode the PTE: V=bit0, R=1, W=2, X=3, PPN=[53:10].
  - Invalid (V=0, or R=0&&W=1) -> FAULT.
  - Leaf (R|X): at level 0 -> DONE with PPN.
  - Leaf at level >0: behaviour is set by Configuration.
  - Pointer (R=X=W=0): at level 0 -> FAULT; otherwise r_ppn=PTE.PPN, r_level-1, go to REQ.
- DONE: o_ptw_valid=1, then go to HOLD. FAULT: o_ptw_fault=1, then go to HOLD.
- HOLD: one cycle in which i_tlb_miss is ignored, because the TLB's registered miss stays high one cycle after the fill. Then go to IDLE.
- No A/D or U/permission checks; those belong downstream.
- Reset mid-walk: all state returns to IDLE at once and any request is dropped. A late response is discarded because the FSM is not in WAIT.
- Reset values: o_ptw_valid=0, o_ptw_fault=0, o_mem_req_valid=0, o_ptw_paddr=0, o_ptw_asid=0, o_mem_req_addr=0.

## Timing
- Only one PTE request is outstanding at a time; no new request is issued before the response arrives.
- o_mem_req_valid, o_ptw_valid and o_ptw_fault are decoded from the state register only, with no combinational input-to-output path.
- Minimum latency (ready=1, response one cycle after acceptance): the miss is seen in cycle 0 and o_ptw_valid is high in cycle 7 for a 4 KiB walk.
- A 1-level fault is reported in cycle 3. A level-1 superpage completes in cycle 5.
- After DONE/FAULT, the earliest next miss capture is in cycle +2 (after HOLD).

## Configuration
- CG_PTW_SUPERPAGE_EN defined: leaf at level 2 or 1 is accepted.
  - Leaf PPN low bits must be zero: [17:0] at level 2, [8:0] at level 1. Otherwise FAULT.
  - Output PPN = {PTE.PPN high bits, vpn bits of the skipped levels}.
- CG_PTW_SUPERPAGE_EN undefined: any leaf at level >0 -> FAULT.

## Structure
- Package cg_ptw_pkg holds:
  - state enum ptw_state_e;
  - PTE bit-position localparams;
  - LEVELS=3 and VPN_BITS=9;
  - struct pte_t.
- Sub-module cg_ptw_pte_check: combinational decode. Inputs PTE and level. Outputs is_invalid, is_leaf, is_misaligned, leaf_ppn (superpage-merged).

## Test plan
- 4 KiB walk:
  - Setup: satp_ppn=0x80000, vaddr=0x40201ABC, PTEs 0x20000401 @0x80000008, 0x20000801 @0x80001008, 0x48D14CF @0x80002008.
  - Response: three requests to exactly those addresses; o_ptw_valid with paddr=0x12345ABC.
- Superpage (macro on): same vaddr, level-1 PTE ppn=0x80200 with RWX -> paddr=0x80201ABC after 2 requests.
- Misaligned superpage: level-1 leaf ppn=0x80201 -> o_ptw_fault. With the macro off, any level-1 leaf -> o_ptw_fault.
- Invalid PTE: level-2 PTE=0x0 -> fault after 1 request. Level-0 pointer PTE 0x1 -> fault.
- Backpressure: i_mem_req_ready low 5 cycles -> addr and valid held stable; walk result unchanged.
- Reset mid-WAIT, then a stale i_mem_resp_valid -> no o_ptw_valid/o_ptw_fault, FSM in IDLE. A miss held high through HOLD -> exactly one walk per miss.
